// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative HI/LO multiply/divide unit for the EX stage.
// One operand bit per cycle; shift-add multiply, restoring divide, MADD/MSUB.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [PW-1:0]   p_q, p_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic            done_q, done_d;

    logic            s1, s2;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]  mul_sum;
    logic [PW-1:0]   mul_nxt;
    logic [WIDTH:0]  div_sh;
    logic [WIDTH-1:0] div_sub;
    logic [PW-1:0]   div_nxt;
    logic [PW-1:0]   prod;
    logic [WIDTH-1:0] quo, rem;
    logic [PW-1:0]   result;

    // Operand conditioning, one iteration step for each algorithm, final fix-up.
    always_comb begin
        s1   = op[0] & d1[WIDTH-1];
        s2   = op[0] & d2[WIDTH-1];
        abs1 = s1 ? -d1 : d1;
        abs2 = s2 ? -d2 : d2;

        mul_sum = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, a_q};
        mul_nxt = p_q[0] ? {mul_sum, p_q[WIDTH-1:1]}
                         : {1'b0, p_q[PW-1:1]};

        // Remainder is shifted one wider so the compare never overflows.
        div_sh  = {p_q[PW-1:WIDTH], p_q[WIDTH-1]};
        div_sub = div_sh[WIDTH-1:0] - a_q;
        div_nxt = (div_sh >= {1'b0, a_q})
                ? {div_sub, p_q[WIDTH-2:0], 1'b1}
                : {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};

        prod = neg_q ? -p_q : p_q;
        quo  = p_q[WIDTH-1:0];
        rem  = p_q[PW-1:WIDTH];

        result = prod;
        unique case (mode_q)
            2'b00: result = prod;
            2'b01: begin
                result[WIDTH-1:0]  = dz_q ? '1 : (neg_q ? -quo : quo);
                result[PW-1:WIDTH] = rneg_q ? -rem : rem;
            end
            2'b10: result = {hi_q, lo_q} + prod;
            2'b11: result = {hi_q, lo_q} - prod;
            default: result = prod;
        endcase
    end

    // Next-state and register updates for the IDLE -> RUN -> FIX sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        a_d     = a_q;
        p_d     = p_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hilo_we) begin
                    if (hilo_sel) hi_d = d1;
                    else          lo_d = d1;
                end
                if (start) begin
                    mode_d  = op[2:1];
                    a_d     = abs2;
                    p_d     = {{WIDTH{1'b0}}, abs1};
                    neg_d   = s1 ^ s2;
                    rneg_d  = s1;
                    dz_d    = (d2 == '0);
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                p_d   = (mode_q == 2'b01) ? div_nxt : mul_nxt;
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                hi_d    = result[PW-1:WIDTH];
                lo_d    = result[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            a_q     <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed and random checks of muldiv_iter
// against a plain-arithmetic HI/LO reference model.
module tb_muldiv_iter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] mhi = 32'h0;
    logic [31:0] mlo = 32'h0;

    localparam logic [31:0] MIN = 32'h8000_0000;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .d1       (d1),
        .d2       (d2),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] ah,
                                          input logic [31:0] al);
        logic [63:0] acc;
        logic [63:0] pu;
        logic [63:0] ps;
        longint sa, sb;
        int ia, ib;
        acc = {ah, al};
        pu  = {32'h0, a} * {32'h0, b};
        sa  = longint'(int'(a));
        sb  = longint'(int'(b));
        ps  = 64'(sa * sb);
        ia  = int'(a);
        ib  = int'(b);
        case (o)
            3'd0: return pu;
            3'd1: return ps;
            3'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == MIN && b == 32'hFFFF_FFFF) return {32'h0, MIN};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            3'd4: return acc + pu;
            3'd5: return acc + ps;
            3'd6: return acc - pu;
            default: return acc - ps;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_hilo(input bit sel, input logic [31:0] v);
        @(negedge clk);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        d1       = v;
        @(posedge clk);
        #1;
        hilo_we = 1'b0;
        if (sel) mhi = v;
        else     mlo = v;
        check("mthi_mtlo", {hi, lo}, {mhi, mlo});
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit we, input bit sel, input bit inj);
        logic [63:0] exp;
        int nb, nd, di;
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        d1       = a;
        d2       = b;
        hilo_we  = we;
        hilo_sel = sel;
        if (we) begin
            if (sel) mhi = a;
            else     mlo = a;
        end
        exp = model(o, a, b, mhi, mlo);
        nb = 0;
        nd = 0;
        di = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            hilo_we = 1'b0;
            if (busy) nb++;
            if (done) begin
                nd++;
                if (di < 0) di = i;
            end
            if (inj && i == 5)
                check({tag, "_hold"}, {hi, lo}, {mhi, mlo});
            if (inj && i == 4) begin
                start    = 1'b1;
                hilo_we  = 1'b1;
                hilo_sel = 1'($urandom % 2);
                op       = 3'($urandom % 8);
                d1       = $urandom;
                d2       = $urandom;
            end
        end
        check({tag, "_busy"}, 64'(nb), 64'd33);
        check({tag, "_ndone"}, 64'(nd), 64'd1);
        check({tag, "_tdone"}, 64'(di), 64'd33);
        check({tag, "_hilo"}, {hi, lo}, exp);
        mhi = exp[63:32];
        mlo = exp[31:0];
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return MIN;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb, nd;
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        hilo_we  = 1'b0;
        hilo_sel = 1'b0;
        d1       = 32'h0;
        d2       = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        check("multu_max_k", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
        check("mult_neg_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mult_min", 3'd1, MIN, MIN, 0, 0, 0);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        check("div_neg_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 3'd3, MIN, 32'hFFFF_FFFF, 0, 0, 0);
        check("div_ovf_k", {hi, lo}, {32'h0, MIN});
        run_op("divu_z", 3'd2, 32'd5, 32'd0, 0, 0, 0);
        run_op("div_z", 3'd3, 32'hFFFF_FFFB, 32'd0, 0, 0, 0);
        check("div_z_k", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);

        write_hilo(1'b0, 32'hFFFF_FFFF);
        write_hilo(1'b1, 32'h0);
        run_op("madd", 3'd5, 32'd1, 32'd1, 0, 0, 0);
        check("madd_k", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op("msubu", 3'd6, 32'd1, 32'd1, 0, 0, 0);
        check("msubu_k", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

        run_op("maddu_we", 3'd4, 32'h1234_5678, 32'h9, 1, 1, 0);
        run_op("msub_we", 3'd7, 32'hFFFF_0000, 32'h7, 1, 0, 0);
        run_op("maddu_inj", 3'd4, 32'hDEAD_BEEF, 32'h3, 0, 0, 1);
        run_op("divu_inj", 3'd2, 32'd1000, 32'd7, 0, 0, 1);

        @(negedge clk);
        start = 1'b1;
        op    = 3'd2;
        d1    = 32'd12345;
        d2    = 32'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                start   = 1'b1;
                hilo_we = 1'b1;
                d1      = 32'hAAAA_5555;
            end else begin
                start   = 1'b0;
                hilo_we = 1'b0;
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hilo", {hi, lo}, 64'h0);
        mhi = 32'h0;
        mlo = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy) nb++;
            if (done) nd++;
        end
        check("arst_nobusy", 64'(nb), 64'd0);
        check("arst_nodone", 64'(nd), 64'd0);
        run_op("post_rst", 3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] ro;
            logic [31:0] ra, rb;
            bit rwe, rsel;
            ro   = 3'($urandom_range(0, 7));
            ra   = pick();
            rb   = pick();
            rwe  = ($urandom_range(0, 3) == 0);
            rsel = 1'($urandom % 2);
            if ($urandom_range(0, 4) == 0)
                write_hilo(1'($urandom % 2), $urandom);
            run_op("rand", ro, ra, rb, rwe, rsel, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
